// File: rtl/snes_pad_responder_if.sv
// Serial pad link between a host (latch, shift clock) and a pad responder.
// The host drives latch and clock; the pad drives serial data back.
interface snes_pad_responder_if;
    logic data_latch;
    logic data_clock;
    logic serial_data;

    modport master (
        output data_latch,
        output data_clock,
        input  serial_data
    );

    modport slave (
        input  data_latch,
        input  data_clock,
        output serial_data
    );
endinterface

// File: rtl/snes_pad_responder.sv
// Game-pad end of the latch/clock serial controller link.
// Shifts an inverted button word back to the host, bit 0 first.
module snes_pad_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_BITS    = 16,
    parameter bit FILL_BIT    = 1'b1
) (
    input  logic                 clock,
    input  logic                 reset,
    snes_pad_responder_if.slave  link,
    input  logic [NUM_BITS-1:0]  buttons,
    output logic                 busy,
    output logic                 frame_done,
    output logic [7:0]           poll_count
);

    localparam int CW = $clog2(NUM_BITS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_DONE
    } state_t;

    logic [SYNC_STAGES-1:0] r_lat_sync;
    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic                   r_lat_prev;
    logic                   r_clk_prev;

    logic w_lat_rise;
    logic w_lat_fall;
    logic w_clk_rise;

    state_t                r_state;
    state_t                w_state_n;
    logic [NUM_BITS-1:0]   r_shift;
    logic [NUM_BITS-1:0]   w_shift_n;
    logic [CW-1:0]         r_cnt;
    logic [CW-1:0]         w_cnt_n;
    logic                  r_busy;
    logic                  w_busy_n;
    logic                  r_done;
    logic                  w_done_n;
    logic [7:0]            r_poll;
    logic [7:0]            w_poll_n;

    // Synchronize host pins into the clock domain and keep last value for edges
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_lat_sync <= '0;
            r_clk_sync <= '0;
            r_lat_prev <= 1'b0;
            r_clk_prev <= 1'b0;
        end else begin
            r_lat_sync <= {r_lat_sync[SYNC_STAGES-2:0], link.data_latch};
            r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], link.data_clock};
            r_lat_prev <= r_lat_sync[SYNC_STAGES-1];
            r_clk_prev <= r_clk_sync[SYNC_STAGES-1];
        end
    end

    assign w_lat_rise = r_lat_sync[SYNC_STAGES-1] & ~r_lat_prev;
    assign w_lat_fall = ~r_lat_sync[SYNC_STAGES-1] & r_lat_prev;
    assign w_clk_rise = r_clk_sync[SYNC_STAGES-1] & ~r_clk_prev;

    // Next state: latch rise always wins; clock rises only count in SHIFT
    always_comb begin
        w_state_n = r_state;
        w_shift_n = r_shift;
        w_cnt_n   = r_cnt;
        w_done_n  = 1'b0;
        w_poll_n  = r_poll;
        if (w_lat_rise) begin
            w_state_n = S_LOAD;
            w_shift_n = ~buttons;
        end else begin
            unique case (r_state)
                S_LOAD: begin
                    if (w_lat_fall) begin
                        w_state_n = S_SHIFT;
                        w_cnt_n   = '0;
                    end else begin
                        w_shift_n = ~buttons;
                    end
                end
                S_SHIFT: begin
                    if (w_clk_rise) begin
                        w_shift_n = {FILL_BIT, r_shift[NUM_BITS-1:1]};
                        w_cnt_n   = r_cnt + 1'b1;
                        if (r_cnt == CW'(NUM_BITS - 1)) begin
                            w_state_n = S_DONE;
                            w_done_n  = 1'b1;
                            w_poll_n  = r_poll + 8'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
        w_busy_n = (w_state_n == S_LOAD) || (w_state_n == S_SHIFT);
    end

    // State, shift register and status registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_shift <= {NUM_BITS{FILL_BIT}};
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_poll  <= 8'd0;
        end else begin
            r_state <= w_state_n;
            r_shift <= w_shift_n;
            r_cnt   <= w_cnt_n;
            r_busy  <= w_busy_n;
            r_done  <= w_done_n;
            r_poll  <= w_poll_n;
        end
    end

    assign link.serial_data = r_shift[0];
    assign busy             = r_busy;
    assign frame_done       = r_done;
    assign poll_count       = r_poll;

endmodule

// File: tb/tb_snes_pad_responder.sv
// Directed bench for the pad responder: the bench plays the host,
// reading frames back and checking them against hand-computed words.
module tb_snes_pad_responder;

    localparam int PH = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] buttons;
    logic        busy;
    logic        fd;
    logic [7:0]  poll;

    int n_chk  = 0;
    int n_err  = 0;
    int fd_cnt = 0;
    int f0;

    logic [31:0] w;

    snes_pad_responder_if link();

    snes_pad_responder dut (
        .clock      (clk),
        .reset      (rst),
        .link       (link),
        .buttons    (buttons),
        .busy       (busy),
        .frame_done (fd),
        .poll_count (poll)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (fd) fd_cnt++;
    end

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic ticks(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic latch_pulse();
        link.data_latch = 1'b1;
        ticks(PH);
        link.data_latch = 1'b0;
        ticks(PH);
    endtask

    task automatic clk_pulse();
        link.data_clock = 1'b1;
        ticks(PH);
        link.data_clock = 1'b0;
        ticks(PH);
    endtask

    task automatic read_bits(int n, output logic [31:0] word);
        word = '0;
        for (int i = 0; i < n; i++) begin
            word[i] = link.serial_data;
            clk_pulse();
        end
    endtask

    initial begin
        rst             = 1'b1;
        buttons         = 16'h0000;
        link.data_latch = 1'b0;
        link.data_clock = 1'b0;
        ticks(3);
        check("rst_serial", {31'd0, link.serial_data}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, fd}, 32'd0);
        check("rst_poll", {24'd0, poll}, 32'd0);
        rst = 1'b0;
        ticks(2);

        // clock pulses in IDLE must be ignored
        for (int i = 0; i < 3; i++) clk_pulse();
        check("idle_serial", {31'd0, link.serial_data}, 32'd1);
        check("idle_busy", {31'd0, busy}, 32'd0);

        // normal frame
        buttons = 16'hA5C3;
        f0 = fd_cnt;
        latch_pulse();
        read_bits(16, w);
        check("frame_a5c3", w, 32'h0000_5A3C);
        check("frame_fd", fd_cnt - f0, 1);
        check("frame_poll", {24'd0, poll}, 32'd1);
        check("frame_tail", {31'd0, link.serial_data}, 32'd1);
        check("frame_busy", {31'd0, busy}, 32'd0);

        // overclocking: 20 pulses, extra bits are fill
        f0 = fd_cnt;
        latch_pulse();
        read_bits(20, w);
        check("over_low", w & 32'hFFFF, 32'h5A3C);
        check("over_fill", w >> 16, 32'hF);
        check("over_fd", fd_cnt - f0, 1);
        check("over_poll", {24'd0, poll}, 32'd2);

        // abort after 5 bits with a new latch
        f0 = fd_cnt;
        latch_pulse();
        read_bits(5, w);
        check("abort_part", w, 32'h1C);
        buttons = 16'hFFFF;
        latch_pulse();
        read_bits(16, w);
        check("abort_word", w, 32'h0);
        check("abort_fd", fd_cnt - f0, 1);
        check("abort_poll", {24'd0, poll}, 32'd3);

        // transparent latch
        buttons = 16'h0000;
        link.data_latch = 1'b1;
        ticks(PH);
        check("trans_busy", {31'd0, busy}, 32'd1);
        check("trans_ser0", {31'd0, link.serial_data}, 32'd1);
        buttons = 16'h0001;
        ticks(1);
        check("trans_ser1", {31'd0, link.serial_data}, 32'd0);
        link.data_latch = 1'b0;
        ticks(PH);
        read_bits(16, w);
        check("trans_word", w, 32'h0000_FFFE);
        check("trans_poll", {24'd0, poll}, 32'd4);

        // collisions: latch+clock rise, then latch fall+clock rise
        buttons = 16'h0F0F;
        f0 = fd_cnt;
        link.data_latch = 1'b1;
        link.data_clock = 1'b1;
        ticks(PH);
        check("coll_busy", {31'd0, busy}, 32'd1);
        check("coll_poll", {24'd0, poll}, 32'd4);
        link.data_clock = 1'b0;
        ticks(PH);
        link.data_latch = 1'b0;
        link.data_clock = 1'b1;
        ticks(PH);
        link.data_clock = 1'b0;
        ticks(PH);
        read_bits(16, w);
        check("coll_word", w, 32'h0000_F0F0);
        check("coll_fd", fd_cnt - f0, 1);

        // loopback: host reassembles the pressed buttons
        buttons = 16'h1234;
        latch_pulse();
        read_bits(16, w);
        check("loop_word", {16'd0, ~w[15:0]}, 32'h1234);
        check("loop_poll", {24'd0, poll}, 32'd6);

        // asynchronous reset in the middle of a shift
        buttons = 16'hFFFF;
        latch_pulse();
        read_bits(5, w);
        check("mid_ser", {31'd0, link.serial_data}, 32'd0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_ser", {31'd0, link.serial_data}, 32'd1);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_done", {31'd0, fd}, 32'd0);
        check("mid_rst_poll", {24'd0, poll}, 32'd0);
        ticks(2);
        rst = 1'b0;
        ticks(2);

        // poll_count wrap after 256 full frames
        f0 = fd_cnt;
        for (int f = 0; f < 255; f++) begin
            latch_pulse();
            for (int i = 0; i < 16; i++) clk_pulse();
        end
        check("wrap_255", {24'd0, poll}, 32'd255);
        latch_pulse();
        for (int i = 0; i < 16; i++) clk_pulse();
        check("wrap_0", {24'd0, poll}, 32'd0);
        check("wrap_fd", fd_cnt - f0, 256);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/snes_pad_responder.md
Name: snes_pad_responder

Overview:
- Emulates the game-pad end of the latch/clock/serial controller link. It is the responder counterpart to the existing controller reader.
- Takes a 16-bit button word from the fabric and drives it serially back to an external host console or reader. The host supplies data_latch and data_clock.
- Used both as a loopback bench partner for the controller reader and as a pad emulator on the JA PMOD header.

Parameters:
- SYNC_STAGES, 2: flops in the input synchronizer on data_latch and data_clock (minimum 2).
- NUM_BITS, 16: bits shifted per frame.
- FILL_BIT, 1: line level driven after all NUM_BITS bits are shifted out, and when idle.

Ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- data_latch  input  1  host latch, asynchronous to clock.
- data_clock  input  1  host shift clock, asynchronous to clock.
- buttons  input  16  button state, 1 = pressed; bit 0 is shifted first.
- serial_data  output  1  serial line to host, active-low (pressed = 0).
- busy  output  1  high in LOAD or SHIFT.
- frame_done  output  1  one-cycle pulse when the last bit's shift edge is consumed.
- poll_count  output  8  count of completed frames, wraps 255 -> 0.

Behaviour:
- Reset is asynchronous and active-high: one clock; reset asserts asynchronously and clears all state.
  - Reset values: state IDLE, shift register all FILL_BIT, serial_data = FILL_BIT, busy = 0, frame_done = 0, poll_count = 0, bit counter = 0, synchronizers = 0.
- Input path: data_latch and data_clock each pass through SYNC_STAGES flops, then one extra edge-detect flop.
  - Rise and fall events are single-cycle strobes.
  - Latency from a pin edge to its strobe is SYNC_STAGES+1 cycles.
- serial_data is driven from a register, always equal to shift_reg[0]. No combinational path from buttons.
- Shift register is NUM_BITS wide, holding the inverted buttons (~buttons).
- States:
  - IDLE: serial_data = FILL_BIT; clock rises are ignored.
    - Latch rise -> LOAD.
  - LOAD: while latch is high, shift_reg <= ~buttons every cycle (latch is transparent).
    - Latch fall -> SHIFT. Bit counter = 0; serial_data now shows ~buttons[0] as sampled on the last LOAD cycle.
    - Clock rises in LOAD are ignored.
  - SHIFT: each clock-rise strobe shifts right; MSB <= FILL_BIT; counter++.
    - On the strobe that brings the counter to NUM_BITS: -> DONE, pulse frame_done, increment poll_count.
    - After that strobe, serial_data = FILL_BIT.
  - DONE: serial_data held at FILL_BIT; extra clock rises are ignored and do not change poll_count.
    - Latch rise -> LOAD.
- Latch rise in any state, including mid-SHIFT, aborts the frame and enters LOAD.
  - An aborted frame gives no frame_done and no poll_count change.
- Latch rise and clock rise strobes in the same cycle: the latch wins and the clock strobe is discarded.
- Latch fall and clock rise strobes in the same cycle: enter SHIFT with counter = 0; the clock strobe is discarded.
- busy = 1 in LOAD or SHIFT, 0 in IDLE or DONE, registered together with the state.
- poll_count is an 8-bit modular counter.
- Reset mid-frame forces IDLE immediately (asynchronous); serial_data = FILL_BIT on the same edge.
- Host timing requirement: data_clock high and low phases each last at least SYNC_STAGES+2 clocks. Faster toggling is out of contract.

Test Plan:
- Reset values: assert reset mid-SHIFT -> serial_data = 1, busy = 0, frame_done = 0, poll_count = 0 without waiting for a clock edge.
- Normal frame: buttons = 16'hA5C3, latch pulse, then 16 data_clock pulses.
  - Sampled serial_data sequence, bit 0 first: 0,0,1,1,1,1,0,0,0,1,0,1,1,0,1,0.
  - Exactly one frame_done pulse; poll_count 0 -> 1.
  - serial_data = 1 afterwards.
- Overclocking and wrap: 20 clock pulses after the latch -> bits 17-20 read 1, still one frame_done.
  - Running 256 full frames wraps poll_count back to 0.
- Abort: latch again after 5 clocks with buttons = 16'hFFFF -> no frame_done.
  - The new frame reads sixteen 0s; poll_count increments only once.
- Transparent latch: change buttons from 16'h0000 to 16'h0001 while latch is high.
  - First bit after the latch falls = 0 (pressed).
  - serial_data follows ~buttons[0] within 1 cycle while in LOAD.
- Collisions: force latch rise and clock rise strobes into the same cycle -> state LOAD, counter unchanged.
  - Clock pulses in IDLE never move serial_data from 1.
- Loopback: wire to the controller reader with buttons = 16'h1234 -> reader's buttons output equals 16'h1234 after one poll.
